simple_fifo_unpacker: RTL and testbench



---
 rtl/simple_adapter_pkg.sv | 42 ++++
 rtl/simple_fifo_unpacker_if.sv | 33 +++
 rtl/simple_fifo_unpacker.sv | 121 ++++++++++++
 tb/tb_simple_fifo_unpacker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/simple_adapter_pkg.sv
// -----------------------------------------------------------------------------
// simple_adapter_pkg
// Shared definitions for the small/big FIFO adapter pair (packer + unpacker).
//   - state_e      : holding state of the serialiser
//   - ratio_of     : wide/narrow width ratio
//   - cnt_width    : beat counter width for a given ratio
//   - ratio_ok     : elaboration check (ratio is a power of two, at least 2)
//   - slice_idx    : which narrow slice of the wide word goes out on a beat
// -----------------------------------------------------------------------------
package simple_adapter_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic int unsigned ratio_of(input int unsigned wide,
                                           input int unsigned narrow);
    return (narrow == 0) ? 0 : wide / narrow;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

  function automatic bit ratio_ok(input int unsigned wide,
                                  input int unsigned narrow);
    int unsigned r;
    if (narrow == 0) return 1'b0;
    if ((wide % narrow) != 0) return 1'b0;
    r = wide / narrow;
    return (r >= 2) && ((r & (r - 1)) == 0);
  endfunction

  // Beat number -> slice index; MS-first order walks the slices downwards.
  function automatic int unsigned slice_idx(input int unsigned beat,
                                            input int unsigned ratio,
                                            input bit          lsb_first);
    return lsb_first ? beat : (ratio - 1 - beat);
  endfunction

endpackage

// File: rtl/simple_fifo_unpacker_if.sv
// -----------------------------------------------------------------------------
// simple_fifo_unpacker_if
// Bundles the FWFT FIFO read port and the narrow valid/ready output stream.
//   fifo_dat/fifo_last/fifo_empty : FIFO head word and status
//   fifo_rd_ena                   : pop request from the unpacker
//   m_valid/m_data/m_last/m_ready : narrow output stream
// Modports: master = unpacker side, slave = FIFO + downstream side.
// -----------------------------------------------------------------------------
interface simple_fifo_unpacker_if #(
  parameter int unsigned DATA_IN_WIDTH  = 128,
  parameter int unsigned DATA_OUT_WIDTH = 16
);

  logic [DATA_IN_WIDTH-1:0]  fifo_dat;
  logic                      fifo_last;
  logic                      fifo_empty;
  logic                      fifo_rd_ena;
  logic                      m_valid;
  logic [DATA_OUT_WIDTH-1:0] m_data;
  logic                      m_last;
  logic                      m_ready;

  modport master (
    input  fifo_dat, fifo_last, fifo_empty, m_ready,
    output fifo_rd_ena, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_dat, fifo_last, fifo_empty, m_ready,
    input  fifo_rd_ena, m_valid, m_data, m_last
  );

endinterface

// File: rtl/simple_fifo_unpacker.sv
// -----------------------------------------------------------------------------
// simple_fifo_unpacker
// Pops wide words from a first-word-fall-through FIFO and serialises each one
// into RATIO narrow beats. The packet-end flag of a word is carried onto its
// final beat. A new word is loaded on the accept of the previous word's final
// beat, so back-to-back words stream without a bubble.
// Ports:
//   clk   : clock, rising edge
//   rstn  : synchronous active-low reset
//   bus   : FIFO read port + output stream (master modport)
//   busy  : a word is held (same as m_valid)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_EMPTY | no word held, m_valid=0, waiting for a non-empty FIFO
// ST_FULL  | word held in sreg, beat cnt on m_data, m_valid=1
// -----------------------------------------------------------------------------
module simple_fifo_unpacker
  import simple_adapter_pkg::*;
#(
  parameter int unsigned DATA_IN_WIDTH  = 128,
  parameter int unsigned DATA_OUT_WIDTH = 16,
  parameter bit          LSB_FIRST      = 1'b1
) (
  input  logic                   clk,
  input  logic                   rstn,
  simple_fifo_unpacker_if.master bus,
  output logic                   busy
);

  localparam int unsigned      RATIO     = ratio_of(DATA_IN_WIDTH, DATA_OUT_WIDTH);
  localparam int unsigned      CNT_W     = cnt_width(RATIO);
  localparam int unsigned      FIRST_IDX = slice_idx(0, RATIO, LSB_FIRST);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RATIO - 1);

  if (!ratio_ok(DATA_IN_WIDTH, DATA_OUT_WIDTH)) begin : g_bad_ratio
    $error("simple_fifo_unpacker: DATA_IN_WIDTH/DATA_OUT_WIDTH must be a power of two >= 2");
  end

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [DATA_IN_WIDTH-1:0]  sreg_q, sreg_d;
  logic                      held_last_q, held_last_d;
  logic [DATA_OUT_WIDTH-1:0] m_data_q, m_data_d;
  logic                      m_valid_q, m_valid_d;
  logic                      m_last_q, m_last_d;

  logic                      accept;
  logic                      final_beat;
  logic                      load;
  logic [CNT_W-1:0]          cnt_nxt;
  logic [CNT_W-1:0]          next_idx;
  logic [DATA_OUT_WIDTH-1:0] sreg_slice [RATIO];

  for (genvar i = 0; i < RATIO; i++) begin : g_slice
    assign sreg_slice[i] = sreg_q[i*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
  end

  assign accept     = m_valid_q & bus.m_ready;
  assign final_beat = (cnt_q == CNT_LAST);
  // rstn is folded in so the FIFO is never popped on a reset edge.
  assign load       = ~bus.fifo_empty & rstn &
                      ((state_q == ST_EMPTY) | (accept & final_beat));
  assign cnt_nxt    = cnt_q + 1'b1;
  assign next_idx   = CNT_W'(slice_idx(32'(cnt_nxt), RATIO, LSB_FIRST));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sreg_d      = sreg_q;
    held_last_d = held_last_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;

    if (load) begin
      sreg_d      = bus.fifo_dat;
      cnt_d       = '0;
      held_last_d = bus.fifo_last;
      m_data_d    = bus.fifo_dat[FIRST_IDX*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
      m_valid_d   = 1'b1;
      m_last_d    = 1'b0;              // first beat is never the last (RATIO >= 2)
      state_d     = ST_FULL;
    end else if (accept && !final_beat) begin
      cnt_d    = cnt_nxt;
      m_data_d = sreg_slice[next_idx];
      m_last_d = held_last_q & (cnt_nxt == CNT_LAST);
    end else if (accept) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      state_d   = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_EMPTY;
      cnt_q       <= '0;
      sreg_q      <= '0;
      held_last_q <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      held_last_q <= held_last_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
    end
  end

  assign bus.fifo_rd_ena = load;
  assign bus.m_valid     = m_valid_q;
  assign bus.m_data      = m_data_q;
  assign bus.m_last      = m_last_q;
  assign busy            = m_valid_q;

endmodule

// File: tb/tb_simple_fifo_unpacker.sv
// -----------------------------------------------------------------------------
// tb_simple_fifo_unpacker
// Two unpacker instances (lane 0: LSB first, lane 1: MS slice first) see the
// same FIFO contents, reset and m_ready. Expected beats are queued when a word
// enters the FIFO model; each lane's monitor compares on every accepted beat
// and checks pop/valid timing against a beats-remaining occupancy model.
// -----------------------------------------------------------------------------
module tb_simple_fifo_unpacker;

  localparam int DIN   = 128;
  localparam int DOUT  = 16;
  localparam int RATIO = DIN / DOUT;

  typedef struct packed {
    logic [DIN-1:0] dat;
    logic           last;
    logic [31:0]    id;
  } word_t;

  typedef struct packed {
    logic [DOUT-1:0] dat;
    logic            last;
    logic [31:0]     id;
  } beat_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic m_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int next_id = 0;

  word_t fifo_q [2][$];
  beat_t exp_q  [2][$];

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int lane,
                     input logic [DIN-1:0] act, input logic [DIN-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s lane%0d actual=%0h required=%0h t=%0t", name, lane, act, exp, $time);
    end
  endtask

  // Enqueue a word in both lanes' FIFOs and queue the beats each lane owes.
  task automatic push_word(input logic [DIN-1:0] w, input logic last);
    word_t wt;
    beat_t bt;
    int    src;
    wt.dat  = w;
    wt.last = last;
    wt.id   = 32'(next_id);
    for (int l = 0; l < 2; l++) begin
      fifo_q[l].push_back(wt);
      for (int k = 0; k < RATIO; k++) begin
        src     = (l == 0) ? k : (RATIO - 1 - k);
        bt.dat  = DOUT'(w >> (DOUT * src));
        bt.last = last && (k == RATIO - 1);
        bt.id   = 32'(next_id);
        exp_q[l].push_back(bt);
      end
    end
    next_id++;
  endtask

  for (genvar L = 0; L < 2; L++) begin : g_lane
    simple_fifo_unpacker_if #(.DATA_IN_WIDTH(DIN), .DATA_OUT_WIDTH(DOUT)) bus();
    logic busy;

    simple_fifo_unpacker #(
      .DATA_IN_WIDTH (DIN),
      .DATA_OUT_WIDTH(DOUT),
      .LSB_FIRST     (L == 0)
    ) u_dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus.master),
      .busy(busy)
    );

    assign bus.m_ready = m_ready;

    initial begin : lane_monitor
      int          rem;       // beats of the held word not yet accepted
      bit          primed;
      bit          was_rst;
      bit          exp_rd;
      bit          acc;
      beat_t       b;
      word_t       h;
      logic [31:0] cur_id;
      rem     = 0;
      primed  = 1'b0;
      was_rst = 1'b0;
      cur_id  = '0;
      bus.fifo_empty = 1'b1;
      bus.fifo_dat   = '0;
      bus.fifo_last  = 1'b0;
      forever begin
        @(negedge clk);
        #1;
        if (fifo_q[L].size() > 0) begin
          bus.fifo_empty = 1'b0;
          bus.fifo_dat   = fifo_q[L][0].dat;
          bus.fifo_last  = fifo_q[L][0].last;
        end else begin
          bus.fifo_empty = 1'b1;
          bus.fifo_dat   = {$urandom, $urandom, $urandom, $urandom};
          bus.fifo_last  = 1'($urandom_range(0, 1));
        end
        #1;
        exp_rd = rstn && (fifo_q[L].size() > 0) && (rem == 0 || (m_ready && rem == 1));
        acc    = rstn && m_ready && (rem > 0);
        if (primed) begin
          if (was_rst) begin
            chk(bus.m_valid == 1'b0, "rst_m_valid", L, DIN'(bus.m_valid), '0);
            chk(bus.m_data == '0,    "rst_m_data",  L, DIN'(bus.m_data),  '0);
            chk(bus.m_last == 1'b0,  "rst_m_last",  L, DIN'(bus.m_last),  '0);
            chk(busy == 1'b0,        "rst_busy",    L, DIN'(busy),        '0);
          end
          chk(bus.m_valid == (rem > 0), "m_valid", L, DIN'(bus.m_valid), DIN'(rem > 0));
          chk(busy == (rem > 0), "busy", L, DIN'(busy), DIN'(rem > 0));
          chk(bus.fifo_rd_ena == exp_rd, "fifo_rd_ena", L, DIN'(bus.fifo_rd_ena), DIN'(exp_rd));
          chk(!(bus.fifo_rd_ena && bus.fifo_empty), "rd_while_empty", L,
              DIN'(bus.fifo_rd_ena), '0);
          if (acc) begin
            if (exp_q[L].size() == 0) begin
              chk(1'b0, "sb_underflow", L, DIN'(bus.m_data), '0);
            end else begin
              b = exp_q[L].pop_front();
              chk(bus.m_data == b.dat,  "m_data", L, DIN'(bus.m_data), DIN'(b.dat));
              chk(bus.m_last == b.last, "m_last", L, DIN'(bus.m_last), DIN'(b.last));
            end
          end
        end
        if (!rstn) begin
          if (rem > 0) begin
            while (exp_q[L].size() > 0 && exp_q[L][0].id == cur_id)
              void'(exp_q[L].pop_front());
          end
          rem    = 0;
          primed = 1'b1;
        end else if (exp_rd) begin
          h      = fifo_q[L].pop_front();
          cur_id = h.id;
          rem    = RATIO;
        end else if (acc) begin
          rem--;
        end
        was_rst = !rstn;
      end
    end
  end

  initial begin : stimulus
    logic [DIN-1:0] w1;
    logic [DIN-1:0] w2;
    bit             done;
    w1 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    w2 = 128'h1F1E_1D1C_1B1A_1918_1716_1514_1312_1110;

    rstn = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1; m_ready = 1'b1;

    // single word, continuous ready
    push_word(w1, 1'b0);
    repeat (12) @(negedge clk);

    // two words back to back, second carries packet end
    push_word(w1, 1'b0);
    push_word(w2, 1'b1);
    repeat (20) @(negedge clk);

    // three cycles of backpressure mid-word
    push_word(w1, 1'b0);
    repeat (4) @(negedge clk);
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    m_ready = 1'b1;
    repeat (10) @(negedge clk);

    // FIFO empty for a few cycles between words
    push_word(w1, 1'b0);
    repeat (11) @(negedge clk);
    push_word(w2, 1'b1);
    repeat (12) @(negedge clk);

    // reset in the middle of a word, next word still queued
    push_word(w1, 1'b0);
    push_word(w2, 1'b1);
    repeat (3) @(negedge clk);
    rstn = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b1; m_ready = 1'b1;
    repeat (20) @(negedge clk);

    // randomized traffic, backpressure and occasional reset
    for (int c = 0; c < 800; c++) begin
      if (fifo_q[0].size() < 4 && $urandom_range(0, 2) == 0)
        push_word({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3) == 0);
      m_ready = ($urandom_range(0, 3) != 0);
      rstn    = ($urandom_range(0, 149) != 0);
      @(negedge clk);
    end

    rstn = 1'b1; m_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (fifo_q[0].size() == 0) && (fifo_q[1].size() == 0) &&
             (exp_q[0].size() == 0) && (exp_q[1].size() == 0);
    end
    chk(done, "drain_timeout", 0, DIN'(exp_q[0].size() + exp_q[1].size()), '0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
